aemb2_ich_refill: RTL and testbench

Instruction-cache refill controller: the Wishbone initiator that services misses of the AEMB2 instruction cache. It detects a fetch miss, drives the IWB bus (`stb`/`adr`) and steers the cache address so that each `iwb_ack_i` writes the returned word into the cache. The cache captures `iwb_dat_i` directly, so no data passes through this block. It sits between the fetch stage, the instruction cache and the IWB port, and stalls the pipeline while a fill is in progress.

---
 rtl/aemb2_pkg.sv | 33 +++
 rtl/aemb2_line_ctr.sv | 33 +++
 rtl/aemb2_ich_refill.sv | 99 +++++++++
 tb/tb_aemb2_ich_refill.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/aemb2_pkg.sv
// Shared AEMB2 instruction-cache constants, fill-state encoding and Wishbone tie-offs.
// Line refill length is selected by AEMB_ICH_LINEFILL_EN (whole line when defined, missed word only otherwise).
package aemb2_pkg;

  localparam int unsigned AEMB_IWB = 32;
  localparam int unsigned AEMB_ICH = 11;
  localparam int unsigned AEMB_IDX = 6;

  localparam int unsigned AW  = AEMB_IWB - 2;
  localparam int unsigned LNE = AEMB_IDX - 2;
  localparam int unsigned BLK = AEMB_ICH - AEMB_IDX;

  localparam logic [3:0] SEL_WORD = 4'hF;
  localparam logic       WRE_RD   = 1'b0;

  // Words still to fetch after the critical word.
`ifdef AEMB_ICH_LINEFILL_EN
  localparam logic [LNE-1:0] RCNT = {LNE{1'b1}};
`else
  localparam logic [LNE-1:0] RCNT = '0;
`endif

  typedef enum logic [1:0] {
    FIL_IDLE = 2'd0,
    FIL_REQ  = 2'd1,
    FIL_DONE = 2'd2
  } fil_state_e;

  function automatic logic [LNE-1:0] wrap_inc(input logic [LNE-1:0] ofs);
    return ofs + LNE'(1);
  endfunction

endpackage

// File: rtl/aemb2_line_ctr.sv
// Word offset within a cache line (wraps modulo line size) plus remaining-word down-counter.
module aemb2_line_ctr
  import aemb2_pkg::*;
(
  input  logic           gclk,
  input  logic           grst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [LNE-1:0] i_ofs,
  output logic [LNE-1:0] o_ofs,
  output logic           o_last
);

  logic [LNE-1:0] r_ofs;
  logic [LNE-1:0] r_rem;

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_ofs <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_ofs <= i_ofs;
      r_rem <= RCNT;
    end else if (i_step) begin
      r_ofs <= wrap_inc(r_ofs);
      r_rem <= r_rem - LNE'(1);
    end
  end

  assign o_ofs  = r_ofs;
  assign o_last = (r_rem == '0);

endmodule

// File: rtl/aemb2_ich_refill.sv
// AEMB2 instruction-cache refill controller: Wishbone initiator filling the cache on a fetch miss.
// Build option AEMB_ICH_LINEFILL_EN: fetch the whole line critical-word-first instead of one word.
module aemb2_ich_refill
  import aemb2_pkg::*;
(
  input  logic          gclk,
  input  logic          grst,
  input  logic          fet_req,
  input  logic [AW-1:0] fet_adr,
  input  logic          ich_hit,
  output logic [AW-1:0] ich_adr,
  output logic          fil_busy,
  output logic [AW-1:0] iwb_adr_o,
  output logic          iwb_stb_o,
  output logic          iwb_wre_o,
  output logic [3:0]    iwb_sel_o,
  input  logic          iwb_ack_i
);

  fil_state_e      r_state;
  fil_state_e      w_state_nxt;
  logic            r_stb;
  logic            w_stb_nxt;
  logic            w_load;
  logic            w_step;
  logic            w_miss;
  logic            w_last;
  logic [AW-1:LNE] r_adr_hi;
  logic [LNE-1:0]  w_ofs;

  assign w_miss = fet_req & ~ich_hit;

  // Upper address bits hold the line; the counter owns the wrapping word offset.
  aemb2_line_ctr u_line_ctr (
    .gclk   (gclk),
    .grst   (grst),
    .i_load (w_load),
    .i_step (w_step),
    .i_ofs  (fet_adr[LNE-1:0]),
    .o_ofs  (w_ofs),
    .o_last (w_last)
  );

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state  <= FIL_IDLE;
      r_stb    <= 1'b0;
      r_adr_hi <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stb   <= w_stb_nxt;
      if (w_load) begin
        r_adr_hi <= fet_adr[AW-1:LNE];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stb_nxt   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      FIL_IDLE: begin
        if (w_miss) begin
          w_state_nxt = FIL_REQ;
          w_stb_nxt   = 1'b1;
          w_load      = 1'b1;
        end
      end
      FIL_REQ: begin
        w_stb_nxt = 1'b1;
        if (iwb_ack_i) begin
          if (w_last) begin
            w_state_nxt = FIL_DONE;
            w_stb_nxt   = 1'b0;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      // Idle cycle lets the cache re-evaluate its hit on the freshly written tag/valid bits.
      FIL_DONE: begin
        w_state_nxt = FIL_IDLE;
      end
      default: begin
        w_state_nxt = FIL_IDLE;
      end
    endcase
  end

  assign iwb_adr_o = {r_adr_hi, w_ofs};
  assign iwb_stb_o = r_stb;
  assign iwb_wre_o = WRE_RD;
  assign iwb_sel_o = SEL_WORD;
  assign ich_adr   = (r_state != FIL_IDLE) ? iwb_adr_o : fet_adr;
  assign fil_busy  = (r_state != FIL_IDLE) | w_miss;

endmodule

// File: tb/tb_aemb2_ich_refill.sv
// Directed self-checking bench for the instruction-cache refill controller.
module tb_aemb2_ich_refill;
  import aemb2_pkg::*;

`ifdef AEMB_ICH_LINEFILL_EN
  localparam int NW = 16;
`else
  localparam int NW = 1;
`endif
  localparam int RST_ACK = (NW < 5) ? NW : 5;

  logic          gclk;
  logic          grst;
  logic          fet_req;
  logic [AW-1:0] fet_adr;
  logic          ich_hit;
  logic [AW-1:0] ich_adr;
  logic          fil_busy;
  logic [AW-1:0] iwb_adr_o;
  logic          iwb_stb_o;
  logic          iwb_wre_o;
  logic [3:0]    iwb_sel_o;
  logic          iwb_ack_i;

  int            checks;
  int            errors;
  logic [AW-1:0] last_adr;

  aemb2_ich_refill dut (
    .gclk      (gclk),
    .grst      (grst),
    .fet_req   (fet_req),
    .fet_adr   (fet_adr),
    .ich_hit   (ich_hit),
    .ich_adr   (ich_adr),
    .fil_busy  (fil_busy),
    .iwb_adr_o (iwb_adr_o),
    .iwb_stb_o (iwb_stb_o),
    .iwb_wre_o (iwb_wre_o),
    .iwb_sel_o (iwb_sel_o),
    .iwb_ack_i (iwb_ack_i)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // Word k of a critical-word-first fill starting at a, wrapping inside the line.
  function automatic logic [AW-1:0] exp_adr(input logic [AW-1:0] a, input int k);
    logic [LNE-1:0] o;
    o = a[LNE-1:0] + LNE'(k);
    return {a[AW-1:LNE], o};
  endfunction

  task automatic test_reset();
    grst = 1'b1; fet_req = 1'b0; ich_hit = 1'b0; iwb_ack_i = 1'b0; fet_adr = 30'h0000_0123;
    tick(); tick();
    @(negedge gclk);
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", iwb_stb_o); end
    checks++; if (iwb_adr_o !== '0) begin errors++; $display("FAIL reset_adr: got %h expected 0", iwb_adr_o); end
    checks++; if (fil_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", fil_busy); end
    checks++; if (ich_adr !== 30'h0000_0123) begin errors++; $display("FAIL reset_ich_adr: got %h expected 123", ich_adr); end
    checks++; if (iwb_sel_o !== 4'hF || iwb_wre_o !== 1'b0) begin errors++; $display("FAIL reset_tieoff: got sel %h wre %b expected F 0", iwb_sel_o, iwb_wre_o); end
    tick();
    grst = 1'b0;
    last_adr = '0;
  endtask

  task automatic test_hit();
    fet_req = 1'b1; ich_hit = 1'b1; fet_adr = 30'h0000_0400;
    @(negedge gclk);
    checks++; if (fil_busy !== 1'b0) begin errors++; $display("FAIL hit_busy: got %b expected 0", fil_busy); end
    checks++; if (ich_adr !== 30'h0000_0400) begin errors++; $display("FAIL hit_ich_adr: got %h expected 400", ich_adr); end
    tick();
    @(negedge gclk);
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL hit_stb: got %b expected 0", iwb_stb_o); end
    tick();
    fet_req = 1'b0;
  endtask

  // Miss at a, each word acked after `waits` idle cycles, then the retried fetch hits.
  task automatic test_fill(input logic [AW-1:0] a, input int waits);
    logic [AW-1:0] e;
    fet_req = 1'b1; ich_hit = 1'b0; fet_adr = a; iwb_ack_i = 1'b0;
    @(negedge gclk);
    checks++; if (fil_busy !== 1'b1) begin errors++; $display("FAIL fill_miss_busy: got %b expected 1", fil_busy); end
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL fill_miss_stb: got %b expected 0", iwb_stb_o); end
    tick();
    fet_adr = a ^ 30'h0000_0100;
    for (int k = 0; k < NW; k++) begin
      e = exp_adr(a, k);
      for (int w = 0; w <= waits; w++) begin
        iwb_ack_i = (w == waits);
        @(negedge gclk);
        checks++; if (iwb_stb_o !== 1'b1) begin errors++; $display("FAIL fill_stb w%0d/%0d: got %b expected 1", k, w, iwb_stb_o); end
        checks++; if (iwb_adr_o !== e) begin errors++; $display("FAIL fill_adr w%0d/%0d: got %h expected %h", k, w, iwb_adr_o, e); end
        checks++; if (ich_adr !== e || fil_busy !== 1'b1) begin errors++; $display("FAIL fill_ich w%0d/%0d: got %h busy %b expected %h busy 1", k, w, ich_adr, fil_busy, e); end
        tick();
      end
    end
    iwb_ack_i = 1'b0;
    @(negedge gclk);
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL fill_done_stb: got %b expected 0", iwb_stb_o); end
    checks++; if (fil_busy !== 1'b1) begin errors++; $display("FAIL fill_done_busy: got %b expected 1", fil_busy); end
    tick();
    fet_adr = a; ich_hit = 1'b1;
    @(negedge gclk);
    checks++; if (fil_busy !== 1'b0) begin errors++; $display("FAIL fill_idle_busy: got %b expected 0", fil_busy); end
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL fill_idle_stb: got %b expected 0", iwb_stb_o); end
    checks++; if (ich_adr !== a) begin errors++; $display("FAIL fill_idle_ich_adr: got %h expected %h", ich_adr, a); end
    tick();
    fet_req = 1'b0;
    last_adr = exp_adr(a, NW - 1);
  endtask

  task automatic test_stray_ack();
    fet_req = 1'b0; ich_hit = 1'b0; iwb_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge gclk);
      checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL stray_stb c%0d: got %b expected 0", i, iwb_stb_o); end
      checks++; if (fil_busy !== 1'b0) begin errors++; $display("FAIL stray_busy c%0d: got %b expected 0", i, fil_busy); end
      checks++; if (iwb_adr_o !== last_adr) begin errors++; $display("FAIL stray_adr c%0d: got %h expected %h", i, iwb_adr_o, last_adr); end
      tick();
    end
    iwb_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    logic [AW-1:0] e;
    fet_req = 1'b1; ich_hit = 1'b0; fet_adr = 30'h0000_0403; iwb_ack_i = 1'b0;
    tick();
    for (int k = 0; k < RST_ACK - 1; k++) begin
      iwb_ack_i = 1'b1;
      tick();
    end
    e = exp_adr(30'h0000_0403, RST_ACK - 1);
    iwb_ack_i = 1'b1; grst = 1'b1; fet_adr = 30'h0000_0555;
    @(negedge gclk);
    checks++; if (iwb_stb_o !== 1'b1 || iwb_adr_o !== e) begin errors++; $display("FAIL rstfill_pre: got stb %b adr %h expected 1 %h", iwb_stb_o, iwb_adr_o, e); end
    tick();
    grst = 1'b0; iwb_ack_i = 1'b0;
    @(negedge gclk);
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL rstfill_stb: got %b expected 0", iwb_stb_o); end
    checks++; if (fil_busy !== 1'b1) begin errors++; $display("FAIL rstfill_busy: got %b expected 1", fil_busy); end
    checks++; if (ich_adr !== 30'h0000_0555) begin errors++; $display("FAIL rstfill_ich_adr: got %h expected 555", ich_adr); end
    tick();
    @(negedge gclk);
    checks++; if (iwb_stb_o !== 1'b1) begin errors++; $display("FAIL rstfill_retry_stb: got %b expected 1", iwb_stb_o); end
    checks++; if (iwb_adr_o !== 30'h0000_0555) begin errors++; $display("FAIL rstfill_retry_adr: got %h expected 555", iwb_adr_o); end
    grst = 1'b1; fet_req = 1'b0;
    tick();
    grst = 1'b0;
    tick();
    last_adr = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    grst = 1'b1; fet_req = 1'b0; fet_adr = '0; ich_hit = 1'b0; iwb_ack_i = 1'b0;
    last_adr = '0;
    test_reset();
    test_hit();
    test_fill(30'h0000_0403, 0);
    test_fill(30'h0000_0A1E, 3);
    test_stray_ack();
    test_reset_mid_fill();
    test_stray_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
